// File: rtl/iris_pkg.sv
// Shared types and helpers for the Iris output-decision logic.
package iris_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} argmax_state_t;

  localparam int IRIS_NUM_CLASSES = 3;

  // Index width for a class count; at least one bit even for a single class.
  function automatic int calc_cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iris_argmax_classifier.sv
// Sequential argmax over the output-layer scores, one class per enabled cycle.
// Lowest index wins on ties; out_tie flags that another class matched the maximum.
module iris_argmax_classifier
  import iris_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int FRAC_BITS   = 4,
  parameter int NUM_CLASSES = IRIS_NUM_CLASSES,
  localparam int CW         = calc_cw(NUM_CLASSES)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              En,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] Y_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CW-1:0]                     class_idx,
  output logic signed [DATA_WIDTH-1:0]      max_val,
  output logic                              out_tie
);

  if (NUM_CLASSES < 1 || NUM_CLASSES > 16 || FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH) begin : g_bad_param
    $error("iris_argmax_classifier: illegal parameter combination");
  end

  argmax_state_t               r_state;
  logic signed [DATA_WIDTH-1:0] r_buf [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] r_best_val;
  logic [CW-1:0]                r_best_idx;
  logic [CW-1:0]                r_cnt;
  logic                         r_tie;
  logic                         r_out_valid;
  logic [CW-1:0]                r_class_idx;
  logic signed [DATA_WIDTH-1:0] r_max_val;
  logic                         r_out_tie;

  logic signed [DATA_WIDTH-1:0] w_y [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] w_s;
  logic                         w_gt;
  logic                         w_eq;
  logic                         w_last;
  logic                         w_accept;
  logic signed [DATA_WIDTH-1:0] w_nxt_val;
  logic [CW-1:0]                w_nxt_idx;
  logic                         w_nxt_tie;

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_unpack
    assign w_y[g] = Y_in[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept = En && in_valid && in_ready;

  // Compare stage: current buffered score against the running best.
  assign w_s       = r_buf[r_cnt];
  assign w_gt      = (w_s > r_best_val);
  assign w_eq      = (w_s == r_best_val);
  assign w_last    = (r_cnt == CW'(NUM_CLASSES - 1));
  assign w_nxt_val = w_gt ? w_s : r_best_val;
  assign w_nxt_idx = w_gt ? r_cnt : r_best_idx;
  assign w_nxt_tie = w_gt ? 1'b0 : (w_eq ? 1'b1 : r_tie);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_best_val  <= '0;
      r_best_idx  <= '0;
      r_cnt       <= '0;
      r_tie       <= 1'b0;
      r_out_valid <= 1'b0;
      r_class_idx <= '0;
      r_max_val   <= '0;
      r_out_tie   <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) r_buf[i] <= '0;
    end else if (En) begin
      if (w_accept) begin
        for (int i = 0; i < NUM_CLASSES; i++) r_buf[i] <= w_y[i];
        r_best_val <= w_y[0];
        r_best_idx <= '0;
        r_tie      <= 1'b0;
        r_cnt      <= CW'(1);
        // A single class needs no scan: its score is the result immediately.
        if (NUM_CLASSES == 1) begin
          r_class_idx <= '0;
          r_max_val   <= w_y[0];
          r_out_tie   <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end else begin
          r_out_valid <= 1'b0;
          r_state     <= SCAN;
        end
      end else begin
        unique case (r_state)
          SCAN: begin
            r_best_val <= w_nxt_val;
            r_best_idx <= w_nxt_idx;
            r_tie      <= w_nxt_tie;
            r_cnt      <= r_cnt + 1'b1;
            if (w_last) begin
              r_class_idx <= w_nxt_idx;
              r_max_val   <= w_nxt_val;
              r_out_tie   <= w_nxt_tie;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end
          DONE: begin
            if (out_ready) begin
              r_out_valid <= 1'b0;
              r_state     <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign out_valid = r_out_valid;
  assign class_idx = r_class_idx;
  assign max_val   = r_max_val;
  assign out_tie   = r_out_tie;

endmodule

// File: tb/tb_iris_argmax_classifier.sv
// Directed scoreboard bench for iris_argmax_classifier (default 3 classes, 8-bit scores).
module tb_iris_argmax_classifier;

  localparam int DW = 8;
  localparam int NC = 3;
  localparam int CW = 2;

  logic               clk;
  logic               rst;
  logic               En;
  logic               in_valid;
  logic               in_ready;
  logic [NC*DW-1:0]   Y_in;
  logic               out_valid;
  logic               out_ready;
  logic [CW-1:0]      class_idx;
  logic signed [DW-1:0] max_val;
  logic               out_tie;

  typedef struct packed {
    logic [CW-1:0]        idx;
    logic signed [DW-1:0] val;
    logic                 tie;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  iris_argmax_classifier #(.DATA_WIDTH(DW), .FRAC_BITS(4), .NUM_CLASSES(NC)) dut (
    .clk(clk), .rst(rst), .En(En), .in_valid(in_valid), .in_ready(in_ready),
    .Y_in(Y_in), .out_valid(out_valid), .out_ready(out_ready),
    .class_idx(class_idx), .max_val(max_val), .out_tie(out_tie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference argmax: strict greater replaces, equality only raises the tie flag.
  function automatic exp_t model(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                                 input logic signed [DW-1:0] c);
    logic signed [DW-1:0] v [3];
    exp_t e;
    v[0] = a; v[1] = b; v[2] = c;
    e.idx = '0; e.val = v[0]; e.tie = 1'b0;
    for (int i = 1; i < 3; i++) begin
      if (v[i] > e.val) begin
        e.val = v[i]; e.idx = CW'(i); e.tie = 1'b0;
      end else if (v[i] == e.val) begin
        e.tie = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic send(input string tag, input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                      input logic signed [DW-1:0] c);
    bit got = 0;
    @(negedge clk);
    Y_in     = {c, b, a};
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) begin got = 1; break; end
      @(negedge clk);
    end
    chk({tag, "_in_ready"}, got, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    sb.push_back(model(a, b, c));
  endtask

  task automatic wait_result(input string tag, input int lat);
    int   n = 0;
    bit   seen = 0;
    exp_t e;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
      chk({tag, "_scan_rdy"}, in_ready, 0);
    end
    chk({tag, "_lat"}, seen ? n : -1, lat);
    chk({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_idx"}, class_idx, e.idx);
      chk({tag, "_val"}, $signed(max_val), e.val);
      chk({tag, "_tie"}, out_tie, e.tie);
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_drop_vld"}, out_valid, 0);
    chk({tag, "_idle_rdy"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; En = 1'b1; in_valid = 1'b0; out_ready = 1'b0; Y_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_vld", out_valid, 0);
    chk("rst_idx", class_idx, 0);
    chk("rst_val", $signed(max_val), 0);
    chk("rst_tie", out_tie, 0);
    chk("rst_rdy", in_ready, 1);

    send("t1", 8'sd3, 8'sd20, 8'sd7);        wait_result("t1", 2); release_out("t1");
    send("t2", 8'sd12, 8'sd12, 8'sd5);       wait_result("t2", 2); release_out("t2");
    send("t3", 8'sd0, 8'sd0, 8'sd0);         wait_result("t3", 2); release_out("t3");
    send("t4", -8'sd5, -8'sd2, -8'sd128);    wait_result("t4", 2); release_out("t4");
    send("t5", -8'sd128, -8'sd128, -8'sd128); wait_result("t5", 2); release_out("t5");

    // Back-pressure with a new vector waiting, then back-to-back accept.
    send("bp_a", 8'sd4, -8'sd3, 8'sd4);
    wait_result("bp_a", 2);
    Y_in     = {8'sd9, 8'sd2, 8'sd1};
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_vld", out_valid, 1);
      chk("bp_hold_rdy", in_ready, 0);
      chk("bp_hold_idx", class_idx, 0);
      chk("bp_hold_val", $signed(max_val), 4);
      chk("bp_hold_tie", out_tie, 1);
    end
    out_ready = 1'b1;
    #1 chk("bp_rdy_comb", in_ready, 1);
    @(posedge clk);
    #1 begin out_ready = 1'b0; in_valid = 1'b0; end
    sb.push_back(model(8'sd1, 8'sd2, 8'sd9));
    @(negedge clk);
    chk("bp_b2b_vld", out_valid, 0);
    chk("bp_b2b_rdy", in_ready, 0);
    chk("bp_scan_hold_idx", class_idx, 0);
    chk("bp_scan_hold_val", $signed(max_val), 4);
    wait_result("bp_b", 2);
    release_out("bp_b");

    // Clock-enable freeze mid-scan: result arrives 3 edges late.
    send("en", 8'sd5, -8'sd7, 8'sd6);
    En = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("en_frz_vld", out_valid, 0);
      chk("en_frz_rdy", in_ready, 0);
      chk("en_frz_idx", class_idx, 2);
    end
    En = 1'b1;
    wait_result("en", 2);
    En = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("en_done_frz_vld", out_valid, 1);
    chk("en_done_frz_val", $signed(max_val), 6);
    En = 1'b1;
    release_out("en");

    // Reset mid-scan aborts the transaction.
    send("rs", 8'sd1, 8'sd50, 8'sd2);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rs_vld", out_valid, 0);
    chk("rs_idx", class_idx, 0);
    chk("rs_val", $signed(max_val), 0);
    chk("rs_tie", out_tie, 0);
    chk("rs_rdy", in_ready, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rs_no_emit", out_valid, 0);

    send("post", -8'sd128, -8'sd128, -8'sd1); wait_result("post", 2); release_out("post");

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iris_argmax_classifier.md
Name: iris_argmax_classifier

Overview:
- Output-decision stage directly downstream of the Iris output-layer neurons.
- Captures the NUM_CLASSES signed fixed-point neuron outputs (Y) as one vector and scans them sequentially, one class per cycle.
- Reports the index of the largest value, the value itself, and a tie flag, over a valid/ready handshake.
- Shares the En clock-enable semantics of the neuron stage.

Parameters:
- DATA_WIDTH, 8, width of each signed class score (Q format matching the neurons).
- FRAC_BITS, 4, fractional bits of the scores; informational only, no arithmetic depends on it.
- NUM_CLASSES, 3, number of class scores; legal range 1..16.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high; overrides En.
- En  in  1  clock enable. When 0, all registers hold, including state and outputs.
- in_valid  in  1  score vector valid.
- in_ready  out  1  block can accept a vector. Combinational from state and out_ready.
- Y_in  in  NUM_CLASSES*DATA_WIDTH  packed signed scores. Class i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- class_idx  out  CW  winning class, where CW = max(1, $clog2(NUM_CLASSES)).
- max_val  out  DATA_WIDTH  signed winning score.
- out_tie  out  1  at least one other class equals max_val.

Behaviour:
- States (package enum): IDLE, SCAN, DONE.
- Reset (rst=1 at a clk edge):
  - state = IDLE.
  - out_valid = 0, class_idx = 0, max_val = 0, out_tie = 0.
  - Internal buffer, best, count and tie registers cleared.
  - Aborts any scan in progress; nothing is emitted for it.
- En=0 freezes everything. Handshake signals remain combinationally evaluated, but no transfer occurs because registers do not update.
- in_ready = (state==IDLE) or (state==DONE and out_ready).
- Accept = En and in_valid and in_ready at a clk edge. On accept:
  - Latch Y_in into the buffer.
  - best_val = score0, best_idx = 0, tie = 0, cnt = 1.
  - Next state is SCAN, or DONE if NUM_CLASSES == 1 (result registers loaded the same edge).
- SCAN, each enabled edge, compares s = buffer[cnt] (signed) against best_val:
  - s > best_val: best_val = s, best_idx = cnt, tie = 0.
  - s == best_val: tie = 1; index is unchanged, so the lowest index wins.
  - s < best_val: no change.
  - cnt increments.
  - When cnt == NUM_CLASSES-1, the edge's compare result is written directly into class_idx/max_val/out_tie, out_valid is set to 1, and state goes to DONE.
- Latency: out_valid rises NUM_CLASSES-1 enabled edges after the accept edge (2 for the default).
- Result hold: class_idx, max_val and out_tie change only on entry to DONE and hold otherwise, including during the next SCAN.
- DONE:
  - Holds out_valid = 1 and stable outputs until out_ready.
  - out_ready without in_valid: out_valid = 0, go to IDLE.
  - out_ready with in_valid: the new vector is accepted the same edge and state goes to SCAN. Back-to-back operation has no bubble other than out_valid dropping.
- in_valid in SCAN, or in DONE without out_ready, is not accepted (in_ready = 0). The upstream must hold the vector.
- Arithmetic: compares only, no adds, so there is no overflow case. Values are full signed range, e.g. -128 is a legal score. All-equal inputs give idx 0 and tie 1.

Decomposition:
- Shared package iris_pkg holds:
  - the state enum argmax_state_t {IDLE, SCAN, DONE};
  - localparam helper CW computation;
  - the NUM_CLASSES default of 3 for the Iris net.
- No sub-module. The single signed compare is inline, and the FSM, counter and result registers sit in one module of roughly 150-200 lines.

Test Plan:
- Reset, then accept Y={3,20,7} (class0..2).
  - Required: out_valid high exactly 2 edges after accept, class_idx=1, max_val=20, out_tie=0.
  - in_ready must be 0 during SCAN.
- Y={12,12,5}.
  - Required: class_idx=0, max_val=12, out_tie=1.
- Y={0,0,0} (all neurons clipped by ReLU).
  - Required: class_idx=0, max_val=0, out_tie=1.
- Negative scores Y={-5,-2,-128}.
  - Required: class_idx=1, max_val=-2, out_tie=0.
- Back-pressure and back-to-back:
  - Hold out_ready=0 for 5 cycles with in_valid=1 and a new vector {1,2,9}.
  - Required while held: outputs stable, no accept.
  - Then raise out_ready. Required: the new vector is accepted on that edge, and 2 edges later class_idx=2, max_val=9.
- En and reset during a scan:
  - Drop En for 3 cycles mid-SCAN. Required: state and outputs frozen, and the result is still correct and delayed by exactly 3 cycles.
  - Separately, assert rst mid-SCAN. Required: out_valid stays 0, outputs are 0, state is IDLE, and in_ready=1 the next cycle.
